// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the fetch/decode pipeline controller.
package pipe_ctrl_pkg;

  // Fetch mode decoded from the hazard unit's controls each cycle.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    HOLD_BR = 2'd2
  } pipe_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  // Sequential fetch address; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Next count: clear wins over increment, increment stops at all-ones.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + ONE;
    end else begin
      value_d = value_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/fetch_decode_pipe_ctrl.sv
// PC and IF/ID register owner: obeys stall/bubble/flush controls from the
// hazard unit, squashes wrong-path fetch on redirect, keeps debug statistics.
module fetch_decode_pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          STALL_LIMIT = 16,
  parameter int          CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             PCWrite,
  input  logic             DecodeRegWrite,
  input  logic             MuxControl,
  input  logic             flushControl,
  input  logic             RedirectValid,
  input  logic [31:0]      RedirectTarget,
  input  logic [31:0]      InstrIn,
  output logic [31:0]      PC,
  output logic [31:0]      IFID_Instr,
  output logic [31:0]      IFID_PCPlus4,
  output logic             IFID_Valid,
  output logic             BubbleEx,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             StallTimeout
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STALL_LIMIT - 1);

  // The fetch mode is a pure function of this cycle's controls: the hazard
  // unit re-issues them every cycle, so nothing about the previous mode
  // changes what happens at the next edge.
  pipe_state_e mode_s;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      pc_plus4_s;
  logic             stall_s;
  logic             redirect_s;
  logic [CNT_W-1:0] consec_s;

  assign pc_plus4_s = pc_next_seq(pc_q);
  assign stall_s    = ~PCWrite;
  // Redirects are only honoured when the PC is allowed to move.
  assign redirect_s = PCWrite & RedirectValid;

  // Decode the fetch mode from PCWrite/flushControl.
  always_comb begin
    mode_s = RUN;
    if (PCWrite) begin
      mode_s = RUN;
    end else if (flushControl) begin
      mode_s = HOLD_BR;
    end else begin
      mode_s = HOLD;
    end
  end

  // Next PC and IF/ID contents for the current mode.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (mode_s)
      RUN: begin
        if (RedirectValid) begin
          // Squash the wrong-path word and jump in the same edge.
          pc_d    = RedirectTarget;
          instr_d = NOP_INSTR;
          pc4_d   = 32'h0000_0000;
          valid_d = 1'b0;
        end else begin
          pc_d = pc_plus4_s;
          if (DecodeRegWrite) begin
            instr_d = InstrIn;
            pc4_d   = pc_plus4_s;
            valid_d = 1'b1;
          end else begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
          end
        end
      end
      HOLD, HOLD_BR: begin
        // PC frozen; IF/ID still follows its own enable in case the two differ.
        pc_d = pc_q;
        if (DecodeRegWrite) begin
          instr_d = InstrIn;
          pc4_d   = pc_plus4_s;
          valid_d = 1'b1;
        end else begin
          instr_d = instr_q;
          pc4_d   = pc4_q;
          valid_d = valid_q;
        end
      end
      default: begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
      end
    endcase
  end

  // Sticky timeout: set on the edge where the consecutive run reaches the limit.
  always_comb begin
    timeout_d = timeout_q;
    if (stall_s && (consec_s >= LIMIT_M1)) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Pipeline state registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc4_q     <= 32'h0000_0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (stall_s),
    .clr   (1'b0),
    .value (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (redirect_s),
    .clr   (1'b0),
    .value (FlushCount)
  );

  sat_counter #(.W(CNT_W)) u_consec_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (stall_s),
    .clr   (PCWrite),
    .value (consec_s)
  );

  assign PC           = pc_q;
  assign IFID_Instr   = instr_q;
  assign IFID_PCPlus4 = pc4_q;
  assign IFID_Valid   = valid_q;
  assign StallTimeout = timeout_q;
  assign BubbleEx     = ~MuxControl;

endmodule

// File: doc/fetch_decode_pipe_ctrl.md
# fetch_decode_pipe_ctrl

Consumer end of the hazard-detection interface: owns the PC register and the IF/ID pipeline register, and obeys the stall, bubble and flush controls issued for the instruction in Decode. It holds fetch during data hazards, squashes the wrong-path fetch after a taken branch or JR redirect, and drives the ID/EX bubble select. It also keeps saturating stall and flush statistics and a sticky stall-timeout flag for debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- STALL_LIMIT, 16, consecutive stall cycles that set StallTimeout
- CNT_W, 16, width of statistics counters
- Clk  in  1  pipeline clock; all state updates on rising edge
- Rst  in  1  reset; one clock, reset is synchronous and active-low
- PCWrite  in  1  1 = PC may advance; 0 = hold PC
- DecodeRegWrite  in  1  1 = IF/ID may load; 0 = hold IF/ID
- MuxControl  in  1  1 = pass Decode controls; 0 = insert bubble into ID/EX
- flushControl  in  1  1 = stall is caused by an unresolved branch/JR operand
- RedirectValid  in  1  taken branch or JR resolved in Decode this cycle
- RedirectTarget  in  32  target PC for RedirectValid
- InstrIn  in  32  instruction memory word at PC
- PC  out  32  current fetch address
- IFID_Instr  out  32  instruction presented to Decode
- IFID_PCPlus4  out  32  PC+4 of IFID_Instr
- IFID_Valid  out  1  0 = IF/ID holds a squashed/reset NOP
- BubbleEx  out  1  ID/EX control-zero select
- StallCount  out  CNT_W  cycles with PCWrite=0, saturating
- FlushCount  out  CNT_W  squashes performed, saturating
- StallTimeout  out  1  sticky; consecutive stalls reached STALL_LIMIT

## Operation
- States: RUN, HOLD (PCWrite=0, flushControl=0), HOLD_BR (PCWrite=0, flushControl=1). Next state is decoded every cycle from PCWrite/flushControl; any state returns to RUN when PCWrite=1.
- RUN, no redirect: PC <= PC+4; IF/ID <= {InstrIn, PC+4}, IFID_Valid <= 1.
- RUN with RedirectValid=1: PC <= RedirectTarget; IF/ID <= {32'h0, 0}, IFID_Valid <= 0; FlushCount += 1.
- HOLD/HOLD_BR: PC held when PCWrite=0, IF/ID held when DecodeRegWrite=0. Each is applied independently if the two ever differ.
- RedirectValid is ignored while PCWrite=0. The source re-asserts it in the release cycle.
- BubbleEx = ~MuxControl, combinational, independent of state.
- Stall counter: increments each PCWrite=0 cycle and clears on PCWrite=1. When it reaches STALL_LIMIT, StallTimeout <= 1 and stays set until reset. The block keeps obeying its inputs after timeout.
- Counters saturate at all-ones and do not wrap.
- PC arithmetic is modulo 2^32. PC 32'hFFFF_FFFC advances to 0.

## Timing
- Reset values (Rst=0 at a clock edge): PC=RESET_PC; IFID_Instr=0, IFID_PCPlus4=0, IFID_Valid=0; StallCount=0, FlushCount=0, StallTimeout=0; state RUN.
- Rst takes priority over all inputs, including mid-stall or mid-redirect. BubbleEx still follows MuxControl during reset.
- Fetch latency: InstrIn sampled at edge N appears on IFID_Instr after edge N.
- Redirect: squash and new PC both take effect at the same edge. The first target instruction reaches IF/ID one edge later, giving a one-cycle branch penalty.
- HOLD_BR→RUN with RedirectValid=1 in the release cycle behaves exactly as a RUN redirect.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, HOLD, HOLD_BR}
  - NOP_INSTR = 32'h0000_0000
  - default RESET_PC
- One sub-module, sat_counter (parameter W; ports inc, clr, value), instantiated three times: StallCount, FlushCount and the consecutive-stall counter.

## Test plan
- Reset then 4 free-run cycles with InstrIn = 32'h2001_0005 → PC sequence 0,4,8,12,16; IFID_PCPlus4 = 4,8,12,16; IFID_Valid=1 from the second edge.
- PCWrite=DecodeRegWrite=MuxControl=0 for 2 cycles at PC=8 → PC and IF/ID frozen, BubbleEx=1, StallCount=2; release → PC=12.
- flushControl=1 stall for 1 cycle, then release with RedirectValid=1, target 32'h40 → PC=0x40, IFID_Instr=0, IFID_Valid=0, FlushCount=1.
- RedirectValid=1 while PCWrite=0 → ignored, PC held, FlushCount unchanged.
- STALL_LIMIT=4, PCWrite=0 for 5 cycles → StallTimeout rises after the 4th edge and stays 1 after release; clears only on Rst=0.
- Rst=0 asserted during a stall with PC=0x20 → next edge PC=RESET_PC, IFID_Valid=0, all counters 0.
